// File: rtl/mito_pkg.sv
// mito_pkg: shared pixel type and helpers for the OFM post-processing stages.
//  DATA_W   pixel width (signed two's complement), matches the OFM output width
//  pix_t    signed pixel type
//  pix_max  signed maximum of two pixels; equal operands return that value
package mito_pkg;

    localparam int DATA_W = 8;

    typedef logic signed [DATA_W-1:0] pix_t;

    // Both operands are signed, so '>' is a signed compare.
    function automatic pix_t pix_max(input pix_t a, input pix_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ofm_pool_linebuf.sv
// ofm_pool_linebuf: single-write / async-read line buffer holding one row of
// horizontal pair-maxima for the 2x2 max-pool. No reset; contents are only
// ever read after the same entry has been written earlier in the frame.
//  clk      in   write clock
//  wr_en    in   write strobe
//  wr_addr  in   write entry
//  wr_data  in   write value
//  rd_addr  in   read entry
//  rd_data  out  combinational read value
module ofm_pool_linebuf #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_addr,
    input  logic signed [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]            rd_addr,
    output logic signed [DATA_W-1:0] rd_data
);

    logic signed [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/ofm_maxpool2x2.sv
// ofm_maxpool2x2: streaming 2x2 / stride-2 max-pool on a raster OFM stream.
// One pixel per accepted beat in, one pooled pixel per 2x2 window out.
//  clk        in   clock, rising edge
//  rst        in   asynchronous active-high reset
//  in_valid   in   input pixel valid
//  in_ready   out  stage can accept an input pixel
//  in_data    in   signed input pixel
//  out_valid  out  pooled pixel valid
//  out_ready  in   downstream accepts pooled pixel
//  out_data   out  signed pooled pixel
//  out_last   out  last pooled pixel of the frame
module ofm_maxpool2x2
    import mito_pkg::*;
#(
    parameter int DATA_W = mito_pkg::DATA_W,
    parameter int FMAP_W = 8,
    parameter int FMAP_H = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_last
);

    localparam int CW    = (FMAP_W > 1) ? $clog2(FMAP_W) : 1;
    localparam int RW    = (FMAP_H > 1) ? $clog2(FMAP_H) : 1;
    localparam int LB_D  = FMAP_W / 2;
    localparam int LB_AW = (LB_D > 1) ? $clog2(LB_D) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(FMAP_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(FMAP_H - 1);

    // The compare helper works on the package pixel type, so the port width
    // has to agree with it.
    if (DATA_W != mito_pkg::DATA_W) begin : g_width_check
        $error("ofm_maxpool2x2: DATA_W must equal mito_pkg::DATA_W");
    end

    logic [CW-1:0]            col_cnt;
    logic [RW-1:0]            row_cnt;
    pix_t                     h_max;
    pix_t                     pair;
    pix_t                     win;
    pix_t                     lb_rd;
    logic [LB_AW-1:0]         lb_addr;
    logic                     accept;
    logic                     odd_col;
    logic                     odd_row;
    logic                     lb_we;

    // One-entry output register without skid: upstream may only push when
    // the register is empty or being drained this cycle.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign odd_col  = col_cnt[0];
    assign odd_row  = row_cnt[0];
    assign lb_addr  = LB_AW'(col_cnt >> 1);
    assign lb_we    = accept && odd_col && !odd_row;

    always_comb begin
        pair = pix_max(h_max, in_data);
        win  = pix_max(lb_rd, pair);
    end

    // Even rows write, odd rows read, so one entry is never read and
    // written in the same cycle.
    ofm_pool_linebuf #(
        .DATA_W (DATA_W),
        .DEPTH  (LB_D),
        .AW     (LB_AW)
    ) u_linebuf (
        .clk     (clk),
        .wr_en   (lb_we),
        .wr_addr (lb_addr),
        .wr_data (pair),
        .rd_addr (lb_addr),
        .rd_data (lb_rd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_cnt   <= '0;
            row_cnt   <= '0;
            h_max     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            // Drain; a window completing this same cycle overrides below.
            if (out_valid && out_ready) out_valid <= 1'b0;

            if (accept) begin
                if (col_cnt == COL_LAST) begin
                    col_cnt <= '0;
                    row_cnt <= (row_cnt == ROW_LAST) ? '0 : row_cnt + 1'b1;
                end else begin
                    col_cnt <= col_cnt + 1'b1;
                end

                if (!odd_col) begin
                    h_max <= in_data;
                end else if (odd_row) begin
                    out_data  <= win;
                    out_valid <= 1'b1;
                    out_last  <= (row_cnt == ROW_LAST) && (col_cnt == COL_LAST);
                end
            end
        end
    end

endmodule
